// File: rtl/plot_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : plot_arbiter
// Description : Round-robin arbiter for three pixel writers sharing one VGA
//               pixel port, with a full-screen clear sweep and a per-grant
//               hold limit. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module plot_arbiter #(
    parameter logic [2:0] CLEAR_COLOUR = 3'b000,
    parameter int         MAX_HOLD     = 4096,
    parameter int         X_MAX        = 159,
    parameter int         Y_MAX        = 119
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req,
    input  logic [7:0] x0,
    input  logic [7:0] x1,
    input  logic [7:0] x2,
    input  logic [6:0] y0,
    input  logic [6:0] y1,
    input  logic [6:0] y2,
    input  logic [2:0] c0,
    input  logic [2:0] c1,
    input  logic [2:0] c2,
    input  logic       plot0,
    input  logic       plot1,
    input  logic       plot2,
    input  logic       clear_req,
    output logic [2:0] gnt,
    output logic       clear_busy,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot
);

    // Hold counter must reach MAX_HOLD itself without wrapping.
    localparam int HW = $clog2(MAX_HOLD + 1);

    localparam logic [HW-1:0] c_MAX_HOLD = HW'(MAX_HOLD);
    localparam logic [7:0]    c_X_MAX    = 8'(X_MAX);
    localparam logic [6:0]    c_Y_MAX    = 7'(Y_MAX);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_GRANT = 2'd1;
    localparam logic [1:0] c_S_CLEAR = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    r_ptr;
    logic [1:0]    r_cur;
    logic [HW-1:0] r_hold;
    logic          r_clear_pending;
    logic [7:0]    r_sx;
    logic [6:0]    r_sy;

    logic [1:0] w_cand1;
    logic [1:0] w_cand2;
    logic       w_found;
    logic [1:0] w_pick;
    logic [1:0] w_next_ptr;
    logic [7:0] w_sel_x;
    logic [6:0] w_sel_y;
    logic [2:0] w_sel_c;
    logic       w_sel_plot;
    logic       w_in_range;
    logic       w_keep;

    // Round-robin search order ptr, ptr+1, ptr+2 (mod 3) and the winner.
    always_comb begin
        w_cand1    = (r_ptr == 2'd2) ? 2'd0 : r_ptr + 2'd1;
        w_cand2    = (r_ptr == 2'd0) ? 2'd2 : r_ptr - 2'd1;
        w_found    = 1'b1;
        w_pick     = r_ptr;
        if (req[r_ptr]) begin
            w_pick = r_ptr;
        end else if (req[w_cand1]) begin
            w_pick = w_cand1;
        end else if (req[w_cand2]) begin
            w_pick = w_cand2;
        end else begin
            w_found = 1'b0;
        end
        w_next_ptr = (w_pick == 2'd2) ? 2'd0 : w_pick + 2'd1;
    end

    // Select the current holder's pixel and decide whether the grant is kept.
    always_comb begin
        w_sel_x    = 8'd0;
        w_sel_y    = 7'd0;
        w_sel_c    = 3'd0;
        w_sel_plot = 1'b0;
        case (r_cur)
            2'd0: begin
                w_sel_x = x0; w_sel_y = y0; w_sel_c = c0; w_sel_plot = plot0;
            end
            2'd1: begin
                w_sel_x = x1; w_sel_y = y1; w_sel_c = c1; w_sel_plot = plot1;
            end
            2'd2: begin
                w_sel_x = x2; w_sel_y = y2; w_sel_c = c2; w_sel_plot = plot2;
            end
            default: begin
                w_sel_plot = 1'b0;
            end
        endcase
        w_in_range = (w_sel_x <= c_X_MAX) && (w_sel_y <= c_Y_MAX);
        w_keep     = req[r_cur] && (r_hold < c_MAX_HOLD);
    end

    // Arbiter / clear-sweep state machine with registered pixel port.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= c_S_IDLE;
            r_ptr           <= 2'd0;
            r_cur           <= 2'd0;
            r_hold          <= '0;
            r_clear_pending <= 1'b0;
            r_sx            <= 8'd0;
            r_sy            <= 7'd0;
            gnt             <= 3'b000;
            clear_busy      <= 1'b0;
            x               <= 8'd0;
            y               <= 7'd0;
            colour          <= 3'd0;
            plot            <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    plot       <= 1'b0;
                    x          <= 8'd0;
                    y          <= 7'd0;
                    colour     <= 3'd0;
                    clear_busy <= 1'b0;
                    gnt        <= 3'b000;
                    // A pending or live clear request outranks every requester.
                    if (clear_req || r_clear_pending) begin
                        r_state         <= c_S_CLEAR;
                        r_clear_pending <= 1'b0;
                        r_sx            <= 8'd0;
                        r_sy            <= 7'd0;
                    end else if (w_found) begin
                        r_state <= c_S_GRANT;
                        gnt     <= 3'b001 << w_pick;
                        r_cur   <= w_pick;
                        r_ptr   <= w_next_ptr;
                        r_hold  <= HW'(1);
                    end
                end
                c_S_GRANT: begin
                    if (clear_req) begin
                        r_clear_pending <= 1'b1;
                    end
                    if (w_keep) begin
                        r_hold <= r_hold + HW'(1);
                        plot   <= w_sel_plot & gnt[r_cur] & w_in_range;
                        x      <= w_sel_x;
                        y      <= w_sel_y;
                        colour <= w_sel_c;
                    end else begin
                        // Dropping the grant leaves one dead cycle in IDLE.
                        r_state <= c_S_IDLE;
                        r_hold  <= '0;
                        gnt     <= 3'b000;
                        plot    <= 1'b0;
                        x       <= 8'd0;
                        y       <= 7'd0;
                        colour  <= 3'd0;
                    end
                end
                c_S_CLEAR: begin
                    gnt        <= 3'b000;
                    plot       <= 1'b1;
                    clear_busy <= 1'b1;
                    x          <= r_sx;
                    y          <= r_sy;
                    colour     <= CLEAR_COLOUR;
                    if (r_sx == c_X_MAX) begin
                        r_sx <= 8'd0;
                        if (r_sy == c_Y_MAX) begin
                            r_sy    <= 7'd0;
                            r_state <= c_S_IDLE;
                        end else begin
                            r_sy <= r_sy + 7'd1;
                        end
                    end else begin
                        r_sx <= r_sx + 8'd1;
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_plot_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_plot_arbiter
// Description : Self-checking bench for plot_arbiter: directed vector table
//               plus hand-written clear-sweep, reset-abort and round-robin
//               sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_plot_arbiter;

    localparam logic [2:0] c_CLR_COL = 3'b110;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] req;
    logic [7:0] x0, x1, x2;
    logic [6:0] y0, y1, y2;
    logic [2:0] c0, c1, c2;
    logic       plot0, plot1, plot2;
    logic       clear_req;
    logic [2:0] gnt;
    logic       clear_busy;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;

    int n_cmp = 0;
    int n_bad = 0;

    plot_arbiter #(
        .CLEAR_COLOUR (c_CLR_COL),
        .MAX_HOLD     (4),
        .X_MAX        (159),
        .Y_MAX        (119)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .x0         (x0),
        .x1         (x1),
        .x2         (x2),
        .y0         (y0),
        .y1         (y1),
        .y2         (y2),
        .c0         (c0),
        .c1         (c1),
        .c2         (c2),
        .plot0      (plot0),
        .plot1      (plot1),
        .plot2      (plot2),
        .clear_req  (clear_req),
        .gnt        (gnt),
        .clear_busy (clear_busy),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [2:0] rq;
        logic       clr;
        logic [2:0] pl;
        logic [7:0] px;
        logic [6:0] py;
        logic [2:0] pc;
        logic [2:0] e_gnt;
        logic       e_plot;
        logic [7:0] e_x;
        logic [6:0] e_y;
        logic [2:0] e_c;
        logic       e_busy;
    } vec_t;

    vec_t tbl [24];

    function automatic vec_t mk(logic rst, logic [2:0] rq, logic clr, logic [2:0] pl,
                                logic [7:0] px, logic [6:0] py, logic [2:0] pc,
                                logic [2:0] eg, logic ep, logic [7:0] ex,
                                logic [6:0] ey, logic [2:0] ec, logic eb);
        vec_t v;
        v.rst = rst; v.rq = rq; v.clr = clr; v.pl = pl;
        v.px = px; v.py = py; v.pc = pc;
        v.e_gnt = eg; v.e_plot = ep; v.e_x = ex; v.e_y = ey; v.e_c = ec; v.e_busy = eb;
        return v;
    endfunction

    // Requester 1/2 pixels are offsets of requester 0 so a wrong mux is visible.
    task automatic drive(logic rst, logic [2:0] rq, logic clr, logic [2:0] pl,
                         logic [7:0] px, logic [6:0] py, logic [2:0] pc);
        reset     = rst;
        req       = rq;
        clear_req = clr;
        plot0 = pl[0]; plot1 = pl[1]; plot2 = pl[2];
        x0 = px; x1 = px + 8'd1; x2 = px + 8'd2;
        y0 = py; y1 = py + 7'd1; y2 = py + 7'd2;
        c0 = pc; c1 = pc ^ 3'd1; c2 = pc ^ 3'd2;
    endtask

    task automatic chk_out(string nm, logic [2:0] eg, logic ep, logic [7:0] ex,
                           logic [6:0] ey, logic [2:0] ec, logic eb);
        n_cmp++;
        if ({gnt, plot, x, y, colour, clear_busy} !== {eg, ep, ex, ey, ec, eb}) begin
            n_bad++;
            $display("FAIL %s: got gnt=%b plot=%b x=%0d y=%0d colour=%b busy=%b, want gnt=%b plot=%b x=%0d y=%0d colour=%b busy=%b",
                     nm, gnt, plot, x, y, colour, clear_busy, eg, ep, ex, ey, ec, eb);
        end
    endtask

    task automatic chk_int(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int bad;
        int pulses;
        int found;
        logic [2:0] rr_exp [7];
        logic [2:0] prev;

        //                rst rq     clr pl     px    py    pc      gnt    pl x    y    c     busy
        tbl[0]  = mk(1, 3'b000, 0, 3'b000,  8'd0,  7'd0, 3'd0,  3'b000, 0, 8'd0,  7'd0,  3'd0, 0);
        tbl[1]  = mk(0, 3'b001, 0, 3'b001, 8'd10, 7'd20, 3'd5,  3'b001, 0, 8'd0,  7'd0,  3'd0, 0);
        tbl[2]  = mk(0, 3'b001, 0, 3'b001, 8'd10, 7'd20, 3'd5,  3'b001, 1, 8'd10, 7'd20, 3'd5, 0);
        tbl[3]  = mk(0, 3'b001, 0, 3'b001, 8'd160,7'd20, 3'd5,  3'b001, 0, 8'd160,7'd20, 3'd5, 0);
        tbl[4]  = mk(0, 3'b001, 0, 3'b001, 8'd10, 7'd119,3'd5,  3'b001, 1, 8'd10, 7'd119,3'd5, 0);
        tbl[5]  = mk(0, 3'b001, 0, 3'b001, 8'd10, 7'd20, 3'd5,  3'b000, 0, 8'd0,  7'd0,  3'd0, 0);
        tbl[6]  = mk(0, 3'b001, 0, 3'b000, 8'd10, 7'd20, 3'd5,  3'b001, 0, 8'd0,  7'd0,  3'd0, 0);
        tbl[7]  = mk(0, 3'b000, 0, 3'b000, 8'd10, 7'd20, 3'd5,  3'b000, 0, 8'd0,  7'd0,  3'd0, 0);
        tbl[8]  = mk(0, 3'b010, 0, 3'b010, 8'd30, 7'd40, 3'd2,  3'b010, 0, 8'd0,  7'd0,  3'd0, 0);
        tbl[9]  = mk(0, 3'b010, 0, 3'b010, 8'd30, 7'd40, 3'd2,  3'b010, 1, 8'd31, 7'd41, 3'd3, 0);
        tbl[10] = mk(0, 3'b010, 0, 3'b010, 8'd30, 7'd120,3'd2,  3'b010, 0, 8'd31, 7'd121,3'd3, 0);
        tbl[11] = mk(0, 3'b110, 0, 3'b000, 8'd30, 7'd40, 3'd2,  3'b010, 0, 8'd31, 7'd41, 3'd3, 0);
        tbl[12] = mk(0, 3'b110, 0, 3'b000, 8'd30, 7'd40, 3'd2,  3'b000, 0, 8'd0,  7'd0,  3'd0, 0);
        tbl[13] = mk(0, 3'b110, 0, 3'b000, 8'd5,  7'd6,  3'd0,  3'b100, 0, 8'd0,  7'd0,  3'd0, 0);
        tbl[14] = mk(0, 3'b110, 0, 3'b100, 8'd5,  7'd6,  3'd0,  3'b100, 1, 8'd7,  7'd8,  3'd2, 0);
        tbl[15] = mk(0, 3'b010, 0, 3'b000, 8'd5,  7'd6,  3'd0,  3'b000, 0, 8'd0,  7'd0,  3'd0, 0);
        tbl[16] = mk(0, 3'b010, 0, 3'b000, 8'd5,  7'd6,  3'd0,  3'b010, 0, 8'd0,  7'd0,  3'd0, 0);
        tbl[17] = mk(1, 3'b010, 0, 3'b010, 8'd5,  7'd6,  3'd0,  3'b000, 0, 8'd0,  7'd0,  3'd0, 0);
        tbl[18] = mk(0, 3'b110, 0, 3'b000, 8'd5,  7'd6,  3'd0,  3'b010, 0, 8'd0,  7'd0,  3'd0, 0);
        tbl[19] = mk(0, 3'b110, 1, 3'b010, 8'd1,  7'd2,  3'd7,  3'b010, 1, 8'd2,  7'd3,  3'd6, 0);
        tbl[20] = mk(0, 3'b100, 0, 3'b000, 8'd1,  7'd2,  3'd7,  3'b000, 0, 8'd0,  7'd0,  3'd0, 0);
        tbl[21] = mk(0, 3'b100, 0, 3'b000, 8'd1,  7'd2,  3'd7,  3'b000, 0, 8'd0,  7'd0,  3'd0, 0);
        tbl[22] = mk(0, 3'b000, 0, 3'b000, 8'd0,  7'd0,  3'd0,  3'b000, 1, 8'd0,  7'd0,  c_CLR_COL, 1);
        tbl[23] = mk(0, 3'b000, 0, 3'b000, 8'd0,  7'd0,  3'd0,  3'b000, 1, 8'd1,  7'd0,  c_CLR_COL, 1);

        drive(1, 3'b000, 0, 3'b000, 8'd0, 7'd0, 3'd0);
        step();
        for (int i = 0; i < 24; i++) begin
            drive(tbl[i].rst, tbl[i].rq, tbl[i].clr, tbl[i].pl, tbl[i].px, tbl[i].py, tbl[i].pc);
            step();
            chk_out($sformatf("vec%0d", i), tbl[i].e_gnt, tbl[i].e_plot, tbl[i].e_x,
                    tbl[i].e_y, tbl[i].e_c, tbl[i].e_busy);
        end

        // Remaining sweep pixels 2..19199; clear_req raised on the last one.
        bad    = 0;
        pulses = 2;
        for (int n = 2; n < 19200; n++) begin
            step();
            if (plot === 1'b1) pulses++;
            if (!(plot === 1'b1 && clear_busy === 1'b1 && gnt === 3'b000 &&
                  colour === c_CLR_COL && int'(x) == n % 160 && int'(y) == n / 160))
                bad++;
        end
        chk_int("sweep_pixels_bad", bad, 0);
        chk_int("sweep_pulses", pulses, 19200);
        chk_out("sweep_last", 3'b000, 1, 8'd159, 7'd119, c_CLR_COL, 1);
        clear_req = 1'b1;
        step();
        chk_out("sweep_end_idle", 3'b000, 0, 8'd0, 7'd0, 3'd0, 0);
        clear_req = 1'b0;
        step();
        chk_out("reclear_start", 3'b000, 1, 8'd0, 7'd0, c_CLR_COL, 1);

        // Abort the second sweep with reset at pixel (50,3).
        found = 0;
        for (int n = 0; n < 700 && found == 0; n++) begin
            step();
            if (plot === 1'b1 && x == 8'd50 && y == 7'd3) found = 1;
        end
        chk_int("reach_50_3", found, 1);
        reset = 1'b1;
        step();
        chk_out("abort_reset", 3'b000, 0, 8'd0, 7'd0, 3'd0, 0);
        reset = 1'b0;
        pulses = 0;
        for (int n = 0; n < 12; n++) begin
            step();
            if (plot !== 1'b0 || clear_busy !== 1'b0) pulses++;
        end
        chk_int("no_resume", pulses, 0);

        // Round robin with all three requesting; each holder drops after one cycle.
        rr_exp[0] = 3'b001; rr_exp[1] = 3'b000; rr_exp[2] = 3'b010; rr_exp[3] = 3'b000;
        rr_exp[4] = 3'b100; rr_exp[5] = 3'b000; rr_exp[6] = 3'b001;
        reset = 1'b1;
        step();
        reset = 1'b0;
        prev  = 3'b000;
        for (int i = 0; i < 7; i++) begin
            req = 3'b111 & ~prev;
            step();
            chk_int($sformatf("rr%0d", i), int'(gnt), int'(rr_exp[i]));
            prev = rr_exp[i];
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/plot_arbiter.md
PLOT_ARBITER -- requirements
Module: plot_arbiter

Interface
REQ-001 Parameter CLEAR_COLOUR, default 3'b000, colour written during a screen clear.
REQ-002 Parameter MAX_HOLD, default 4096, maximum consecutive cycles one requester may hold the grant.
REQ-003 Parameter X_MAX, default 159, and Y_MAX, default 119, are the last valid pixel coordinates.
REQ-004 clk  in  1  system clock; all logic is on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req  in  3  per-requester request for the pixel write port; index 0..2.
REQ-007 x0/x1/x2  in  8 each  requester pixel x.
REQ-008 y0/y1/y2  in  7 each  requester pixel y.
REQ-009 c0/c1/c2  in  3 each  requester colour.
REQ-010 plot0/plot1/plot2  in  1 each  requester pixel-write strobe.
REQ-011 clear_req  in  1  request a full-screen clear (level; sampled each cycle).
REQ-012 gnt  out  3  one-hot grant; all zero when no requester is granted.
REQ-013 clear_busy  out  1  high while the clear sweep runs.
REQ-014 x  out  8,  y  out  7,  colour  out  3,  plot  out  1  registered pixel port to the VGA adapter.

Function
REQ-015 States: IDLE, GRANT, CLEAR; all outputs are registered.
REQ-016 Each IDLE cycle with clear_req high or clear_pending set SHALL move to CLEAR; the clear takes priority over req.
REQ-017 Each IDLE cycle with no clear condition and req nonzero SHALL grant one requester round-robin: search starts at ptr and advances ptr+1, ptr+2 mod 3; gnt is asserted the following cycle; state becomes GRANT.
REQ-018 ptr SHALL reset to 0 and be set to (k+1) mod 3 when requester k is granted.
REQ-019 In GRANT the hold counter starts at 1 and increments every cycle; the grant is kept while req[k]=1 and hold<MAX_HOLD.
REQ-020 When req[k]=0 or hold=MAX_HOLD, gnt SHALL go to zero next cycle and state return to IDLE; one dead cycle always separates grants.
REQ-021 In GRANT: plot SHALL be plotk & gnt[k] & (xk<=X_MAX) & (yk<=Y_MAX), registered with 1-cycle latency; x/y/colour = xk/yk/ck registered.
REQ-022 Out-of-range coordinates SHALL suppress plot only; the grant is unaffected.
REQ-023 Requester strobes while not granted SHALL be ignored, not queued.
REQ-024 clear_req high in GRANT SHALL set clear_pending; clear_pending is serviced at the next IDLE and cleared on entry to CLEAR.
REQ-025 CLEAR SHALL sweep x 0..X_MAX (inner), y 0..Y_MAX (outer), one pixel per cycle, plot=1, colour=CLEAR_COLOUR: (X_MAX+1)*(Y_MAX+1) = 19200 writes at default.
REQ-026 clear_busy SHALL be high for exactly the sweep cycles; gnt SHALL be 0 throughout CLEAR.
REQ-027 After the write of (X_MAX,Y_MAX) the state SHALL return to IDLE; clear_req still high at that point starts a new clear.
REQ-028 In IDLE, and on the cycle after a grant drops, plot SHALL be 0 and x/y/colour SHALL be 0.
REQ-029 Counters SHALL be sized to hold MAX_HOLD and X_MAX/Y_MAX without wrap; no coordinate arithmetic overflows.

Reset
REQ-030 reset SHALL force, in the next cycle: state IDLE, gnt=0, plot=0, x=0, y=0, colour=0, clear_busy=0, ptr=0, hold=0, clear_pending=0, sweep counters=0.
REQ-031 reset during CLEAR or GRANT SHALL abort the operation with no further plot pulses; the sweep does not resume.

Verification
REQ-032 After reset, req=3'b111 held: gnt sequence 001, 000, 010, 000, 100, 000, 001 when each holder drops req after 1 cycle.
REQ-033 Granted req0 with x0=10, y0=20, c0=3'b101, plot0=1 -> next cycle x=10, y=20, colour=101, plot=1; x0=160 -> plot=0 while gnt stays 001.
REQ-034 MAX_HOLD=4, req1 held: gnt=010 for 4 cycles, 000 for 1 cycle, then regranted; with req2 also high, gnt=100 next.
REQ-035 clear_req pulsed during GRANT: clear_busy rises after the grant ends, exactly 19200 plot pulses follow with colour=CLEAR_COLOUR, last at (159,119), then IDLE.
REQ-036 reset asserted at sweep pixel (50,3): next cycle plot=0, clear_busy=0, gnt=0; no further writes until a new request.
